// File: rtl/la_pkg.sv
// Shared types for the logic-analyzer UART packet path: FSM encodings and the
// packet header constant.
package la_pkg;

    localparam logic [7:0] LA_PACKET_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        PK_IDLE,
        PK_HDR,
        PK_LEN_LO,
        PK_LEN_HI,
        PK_FETCH,
        PK_DATA,
        PK_CSUM,
        PK_FIN
    } pkt_state_e;

    typedef enum logic [1:0] {
        SND_IDLE,
        SND_SEND,
        SND_WAIT_ACT,
        SND_WAIT_IDLE
    } snd_state_e;

endpackage

// File: rtl/uart_byte_sender.sv
// One-byte-at-a-time handshake to uart_tx: strobe, wait for active, wait for idle.
// byte_ready is combinational so a new byte can be accepted the cycle the line goes idle.
module uart_byte_sender
    import la_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx_send_byte,
    output logic [7:0] tx_byte,
    input  logic       tx_active
);

    snd_state_e r_state, w_state_nxt;
    logic       r_send,  w_send_nxt;
    logic [7:0] r_byte,  w_byte_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SND_IDLE;
            r_send  <= 1'b0;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_send  <= w_send_nxt;
            r_byte  <= w_byte_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_send_nxt  = 1'b0;
        w_byte_nxt  = r_byte;
        byte_ready  = 1'b0;
        case (r_state)
            SND_IDLE:      byte_ready = 1'b1;
            SND_SEND:      w_state_nxt = SND_WAIT_ACT;
            SND_WAIT_ACT:  if (tx_active) w_state_nxt = SND_WAIT_IDLE;
            SND_WAIT_IDLE: begin
                if (!tx_active) begin
                    byte_ready  = 1'b1;
                    w_state_nxt = SND_IDLE;
                end
            end
            default:       w_state_nxt = SND_IDLE;
        endcase
        // tx_byte only changes on acceptance, so it holds until the byte completes
        if (byte_ready && byte_valid) begin
            w_state_nxt = SND_SEND;
            w_send_nxt  = 1'b1;
            w_byte_nxt  = byte_data;
        end
    end

    assign tx_send_byte = r_send;
    assign tx_byte      = r_byte;

endmodule

// File: rtl/uart_tx_packetizer.sv
// Frames a block of sample memory as HEADER, 16-bit length, payload [, XOR checksum]
// and streams it through uart_tx. Checksum byte present when UART_PACKET_CHECKSUM_EN is defined.
module uart_tx_packetizer
    import la_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter logic [7:0]  HEADER = LA_PACKET_HEADER
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              tx_send_byte,
    output logic [7:0]        tx_byte,
    input  logic              tx_active,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LEN_FIELD_W = 16;

    pkt_state_e        r_state,    w_state_nxt;
    logic [ADDR_W-1:0] r_len,      w_len_nxt;
    logic [ADDR_W-1:0] r_idx,      w_idx_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              r_done,     w_done_nxt;
    logic              r_mem_ok,   w_mem_ok_nxt;
`ifdef UART_PACKET_CHECKSUM_EN
    logic [7:0]        r_csum,     w_csum_nxt;
`endif

    logic                   w_byte_valid;
    logic [7:0]             w_byte_data;
    logic                   w_byte_ready;
    logic                   w_last;
    logic [LEN_FIELD_W-1:0] w_len16;

    assign w_len16 = LEN_FIELD_W'(r_len);

    uart_byte_sender u_sender (
        .clock        (clock),
        .reset_n      (reset_n),
        .byte_valid   (w_byte_valid),
        .byte_data    (w_byte_data),
        .byte_ready   (w_byte_ready),
        .tx_send_byte (tx_send_byte),
        .tx_byte      (tx_byte),
        .tx_active    (tx_active)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= PK_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_ok   <= 1'b0;
`ifdef UART_PACKET_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_mem_ok   <= w_mem_ok_nxt;
`ifdef UART_PACKET_CHECKSUM_EN
            r_csum     <= w_csum_nxt;
`endif
        end
    end

    // Each sending state means "that byte is in flight"; the next byte is issued
    // the cycle the sender reports the previous one complete.
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_idx_nxt      = r_idx;
        w_mem_addr_nxt = r_mem_addr;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_mem_ok_nxt   = 1'b0;
        w_byte_valid   = 1'b0;
        w_byte_data    = 8'h00;
        w_last         = 1'b0;
        case (r_state)
            PK_IDLE: begin
                if (start) begin
                    w_len_nxt    = len;
                    w_idx_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                    w_byte_valid = 1'b1;
                    w_byte_data  = HEADER;
                    w_state_nxt  = PK_HDR;
                end
            end
            PK_HDR: begin
                if (w_byte_ready) begin
                    w_byte_valid = 1'b1;
                    w_byte_data  = w_len16[7:0];
                    w_state_nxt  = PK_LEN_LO;
                end
            end
            PK_LEN_LO: begin
                if (w_byte_ready) begin
                    w_byte_valid = 1'b1;
                    w_byte_data  = w_len16[15:8];
                    w_state_nxt  = PK_LEN_HI;
                end
            end
            PK_LEN_HI: begin
                if (w_byte_ready) begin
                    if (r_len == '0) begin
                        w_last = 1'b1;
                    end else begin
                        w_mem_addr_nxt = r_idx;
                        w_state_nxt    = PK_FETCH;
                    end
                end
            end
            PK_FETCH: begin
                // First cycle presents the address; second cycle sees mem_data
                if (!r_mem_ok) begin
                    w_mem_ok_nxt = 1'b1;
                end else begin
                    w_byte_valid = 1'b1;
                    w_byte_data  = mem_data;
                    w_idx_nxt    = r_idx + ADDR_W'(1);
                    w_state_nxt  = PK_DATA;
                end
            end
            PK_DATA: begin
                if (w_byte_ready) begin
                    if (r_idx < r_len) begin
                        w_mem_addr_nxt = r_idx;
                        w_state_nxt    = PK_FETCH;
                    end else begin
                        w_last = 1'b1;
                    end
                end
            end
            PK_CSUM: begin
                if (w_byte_ready) begin
                    w_state_nxt = PK_FIN;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            PK_FIN:  w_state_nxt = PK_IDLE;
            default: w_state_nxt = PK_IDLE;
        endcase
`ifdef UART_PACKET_CHECKSUM_EN
        w_csum_nxt = r_csum;
        if (w_last) begin
            w_byte_valid = 1'b1;
            w_byte_data  = r_csum;
            w_state_nxt  = PK_CSUM;
        end
        // Header is issued from IDLE, so it never enters the fold
        if (r_state == PK_IDLE) begin
            w_csum_nxt = 8'h00;
        end else if (w_byte_valid && !w_last) begin
            w_csum_nxt = r_csum ^ w_byte_data;
        end
`else
        if (w_last) begin
            w_state_nxt = PK_FIN;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
        end
`endif
    end

    assign mem_addr = r_mem_addr;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Scoreboard bench for uart_tx_packetizer: expected bytes are queued by the
// stimulus, and a monitor pops and compares on every tx_send_byte strobe.
module tb_uart_tx_packetizer;

    localparam int unsigned ADDR_W = 9;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic              start   = 1'b0;
    logic [ADDR_W-1:0] len     = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data = 8'h00;
    logic              tx_send_byte;
    logic [7:0]        tx_byte;
    logic              tx_active = 1'b0;
    logic              busy;
    logic              done;

    logic [7:0] mem [0:511];
    logic [7:0] exp_q [$];
    logic [7:0] last_byte = 8'h00;
    int         act_cnt   = 0;
    int         checks    = 0;
    int         errors    = 0;
    int         n_strobes = 0;
    int         n_done    = 0;

    uart_tx_packetizer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .len          (len),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .tx_send_byte (tx_send_byte),
        .tx_byte      (tx_byte),
        .tx_active    (tx_active),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) mem_data <= mem[mem_addr];

    // uart_tx model: active for 10 cycles starting the cycle after the strobe
    always @(posedge clock) begin
        if (tx_send_byte) begin
            act_cnt   <= 10;
            tx_active <= 1'b1;
        end else if (act_cnt > 1) begin
            act_cnt <= act_cnt - 1;
        end else if (act_cnt == 1) begin
            act_cnt   <= 0;
            tx_active <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (tx_send_byte) begin
            n_strobes++;
            last_byte = tx_byte;
            check("no_strobe_while_active", 32'(tx_active), 32'd0);
            check("busy_at_strobe", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none at %0t", tx_byte, $time);
            end else begin
                check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
            end
        end else if (tx_active && busy) begin
            check("tx_byte_stable", 32'(tx_byte), 32'(last_byte));
        end
        if (done) begin
            n_done++;
            check("busy_low_at_done", 32'(busy), 32'd0);
            check("all_bytes_at_done", 32'(exp_q.size()), 32'd0);
        end
    end

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic pulse_start(input int l);
        @(negedge clock);
        start = 1'b1;
        len   = ADDR_W'(l);
        @(negedge clock);
        start = 1'b0;
        check("busy_cycle1", 32'(busy), 32'd1);
        check("strobe_cycle1", 32'(tx_send_byte), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string name, output bit addr_moved);
        bit             seen = 1'b0;
        logic [ADDR_W-1:0] a0 = mem_addr;
        addr_moved = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (mem_addr !== a0) addr_moved = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        end
    endtask

    initial begin
        bit moved;
        int base;

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobe", 32'(tx_send_byte), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Case 1: len=3
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        base = n_done;
        push(8'hA5); push(8'h03); push(8'h00); push(8'h11); push(8'h22); push(8'h33);
`ifdef UART_PACKET_CHECKSUM_EN
        push(8'h03);
`endif
        pulse_start(3);
        wait_done(200, "len3", moved);
        repeat (3) @(negedge clock);
        check("len3_done_count", 32'(n_done - base), 32'd1);
        check("len3_mem_addr", 32'(mem_addr), 32'd2);

        // Case 2: len=0, no memory reads
        base = n_done;
        push(8'hA5); push(8'h00); push(8'h00);
`ifdef UART_PACKET_CHECKSUM_EN
        push(8'h00);
`endif
        pulse_start(0);
        wait_done(200, "len0", moved);
        repeat (3) @(negedge clock);
        check("len0_done_count", 32'(n_done - base), 32'd1);
        check("len0_no_fetch", 32'(moved), 32'd0);

        // Case 4: start while busy is ignored
        base = n_done;
        push(8'hA5); push(8'h03); push(8'h00); push(8'h11); push(8'h22); push(8'h33);
`ifdef UART_PACKET_CHECKSUM_EN
        push(8'h03);
`endif
        pulse_start(3);
        repeat (25) @(negedge clock);
        start = 1'b1;
        len   = ADDR_W'(5);
        @(negedge clock);
        start = 1'b0;
        wait_done(200, "ignore_start", moved);
        repeat (150) @(negedge clock);
        check("ignore_done_count", 32'(n_done - base), 32'd1);
        check("ignore_busy_idle", 32'(busy), 32'd0);

        // Case 3: maximum length, memory[i] = i
        for (int i = 0; i < 512; i++) mem[i] = 8'(i);
        base = n_done;
        push(8'hA5); push(8'hFF); push(8'h01);
        for (int i = 0; i < 511; i++) push(8'(i));
`ifdef UART_PACKET_CHECKSUM_EN
        push(8'h01);
`endif
        pulse_start(511);
        wait_done(12000, "len511", moved);
        repeat (3) @(negedge clock);
        check("len511_done_count", 32'(n_done - base), 32'd1);
        check("len511_last_addr", 32'(mem_addr), 32'd510);

        // Case 5: reset during a payload byte, then a clean packet
        mem[0] = 8'h5C; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h03;
        push(8'hA5); push(8'h04); push(8'h00); push(8'h5C); push(8'h01); push(8'h02); push(8'h03);
        base = n_strobes;
        pulse_start(4);
        for (int i = 0; i < 300 && n_strobes < base + 5; i++) @(negedge clock);
        check("rst_mid_reached", 32'(n_strobes - base >= 5), 32'd1);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_strobe", 32'(tx_send_byte), 32'd0);
        check("midrst_tx_byte", 32'(tx_byte), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 50 && tx_active; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        base = n_done;
        push(8'hA5); push(8'h01); push(8'h00); push(8'h5C);
`ifdef UART_PACKET_CHECKSUM_EN
        push(8'h5D);
`endif
        pulse_start(1);
        wait_done(200, "post_reset", moved);
        repeat (3) @(negedge clock);
        check("post_reset_done_count", 32'(n_done - base), 32'd1);

        // Case 6: len=2
        mem[0] = 8'hC3; mem[1] = 8'h3C;
        base = n_done;
        push(8'hA5); push(8'h02); push(8'h00); push(8'hC3); push(8'h3C);
`ifdef UART_PACKET_CHECKSUM_EN
        push(8'hFD);
`endif
        pulse_start(2);
        wait_done(200, "len2", moved);
        repeat (30) @(negedge clock);
        check("len2_done_count", 32'(n_done - base), 32'd1);
        check("len2_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
